// File: rtl/spi_slave_if.sv
// Host-side handshake bundle for spi_slave: one-entry TX offer and received-byte delivery.
interface spi_slave_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI responder, modes 0-3, MSB first; SCLK/MOSI/SS_N are synchronised into clk.
// Optional SPI_SLAVE_MISO_TRI_EN: MISO floats (1'bz) whenever the block is not ACTIVE.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CPOL,
    input  logic        CPHA,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_N,
    output logic        MISO,
    spi_slave_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    state_t                 state_r, state_nx;
    logic [SYNC_STAGES-1:0] sclk_sync_r, mosi_sync_r, ssn_sync_r;
    logic                   sclk_prev_r, ssn_prev_r;
    logic                   cpol_r, cpol_nx, cpha_r, cpha_nx;
    logic [CNT_W-1:0]       cnt_r, cnt_nx;
    logic [DATA_W-1:0]      rx_shift_r, rx_shift_nx, shift_r, shift_nx, shift_adv_s;
    logic [DATA_W-1:0]      rx_data_r, rx_data_nx, buf_r, buf_nx;
    logic                   rx_valid_r, rx_valid_nx, tx_ready_r, tx_ready_nx;
    logic                   busy_r, busy_nx, miso_r, miso_nx;
    logic                   sclk_s, ssn_s, mosi_s, sclk_rise_s, sclk_fall_s, ss_fall_s, ss_rise_s;
    logic                   lead_s, trail_s, sample_s, launch_s, load_s, accept_s;

    // Input synchronisers plus one extra stage for edge detection. SS_N resets low so that
    // leaving reset with SS_N already low produces no falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            ssn_sync_r  <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b0;
            ssn_prev_r  <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
            ssn_sync_r  <= {ssn_sync_r[SYNC_STAGES-2:0], SS_N};
            sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
            ssn_prev_r  <= ssn_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign ssn_s       = ssn_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_s & sclk_prev_r;
    assign ss_fall_s   = ~ssn_s & ssn_prev_r;
    assign ss_rise_s   = ssn_s & ~ssn_prev_r;
    assign lead_s      = cpol_r ? sclk_fall_s : sclk_rise_s;
    assign trail_s     = cpol_r ? sclk_rise_s : sclk_fall_s;
    assign sample_s    = cpha_r ? trail_s : lead_s;
    // With CPHA=1 the MSB is already on MISO, so the first leading edge of each byte does not shift.
    assign launch_s    = cpha_r ? (lead_s && (cnt_r != {CNT_W{1'b0}})) : trail_s;
    assign accept_s    = bus.tx_valid && tx_ready_r;

    // Next-state: frame FSM, bit counter, shift registers, TX buffer and output values.
    always_comb begin
        state_nx    = state_r;
        cpol_nx     = cpol_r;
        cpha_nx     = cpha_r;
        cnt_nx      = cnt_r;
        rx_shift_nx = rx_shift_r;
        rx_data_nx  = rx_data_r;
        rx_valid_nx = 1'b0;
        shift_adv_s = shift_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    state_nx = ST_ACTIVE;
                    cpol_nx  = CPOL;
                    cpha_nx  = CPHA;
                    cnt_nx   = {CNT_W{1'b0}};
                    load_s   = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_s) begin
                    state_nx = ST_IDLE;
                end else if (sample_s) begin
                    rx_shift_nx = {rx_shift_r[DATA_W-2:0], mosi_s};
                    if (cnt_r == CNT_W'(DATA_W - 1)) begin
                        cnt_nx      = {CNT_W{1'b0}};
                        rx_data_nx  = rx_shift_nx;
                        rx_valid_nx = 1'b1;
                        load_s      = cpha_r;
                    end else begin
                        cnt_nx = cnt_r + CNT_W'(1);
                    end
                end else if (launch_s) begin
                    // A trailing edge with the counter at zero follows a completed byte in CPHA=0.
                    if (!cpha_r && (cnt_r == {CNT_W{1'b0}})) begin
                        load_s = 1'b1;
                    end else begin
                        shift_adv_s = {shift_r[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    state_nx = ST_ACTIVE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        shift_nx = load_s ? (tx_ready_r ? {DATA_W{1'b0}} : buf_r) : shift_adv_s;

        if (accept_s) begin
            buf_nx      = bus.tx_data;
            tx_ready_nx = 1'b0;
        end else if (load_s && !tx_ready_r) begin
            buf_nx      = buf_r;
            tx_ready_nx = 1'b1;
        end else begin
            buf_nx      = buf_r;
            tx_ready_nx = tx_ready_r;
        end

        busy_nx = (state_nx == ST_ACTIVE);
        miso_nx = (state_nx == ST_ACTIVE) ? shift_nx[DATA_W-1] : 1'b0;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            rx_shift_r <= {DATA_W{1'b0}};
            shift_r    <= {DATA_W{1'b0}};
            rx_data_r  <= {DATA_W{1'b0}};
            buf_r      <= {DATA_W{1'b0}};
            rx_valid_r <= 1'b0;
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            miso_r     <= 1'b0;
        end else begin
            state_r    <= state_nx;
            cpol_r     <= cpol_nx;
            cpha_r     <= cpha_nx;
            cnt_r      <= cnt_nx;
            rx_shift_r <= rx_shift_nx;
            shift_r    <= shift_nx;
            rx_data_r  <= rx_data_nx;
            buf_r      <= buf_nx;
            rx_valid_r <= rx_valid_nx;
            tx_ready_r <= tx_ready_nx;
            busy_r     <= busy_nx;
            miso_r     <= miso_nx;
        end
    end

    assign bus.tx_ready = tx_ready_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.busy     = busy_r;

`ifdef SPI_SLAVE_MISO_TRI_EN
    assign MISO = busy_r ? miso_r : 1'bz;
`else
    assign MISO = miso_r;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: SPI master model with MISO/RX scoreboards.
module tb_spi_slave;
    localparam int DATA_W = 8;
    localparam int HALF   = 8;

    logic clk = 1'b0, rst = 1'b1;
    logic CPOL = 1'b0, CPHA = 1'b0, SCLK = 1'b0, MOSI = 1'b0, SS_N = 1'b1;
    wire  MISO;

    spi_slave_if #(.DATA_W(DATA_W)) bus ();

    spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .CPOL(CPOL), .CPHA(CPHA), .SCLK(SCLK),
        .MOSI(MOSI), .SS_N(SS_N), .MISO(MISO), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, rx_pulses = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] miso_exp_q[$];
`ifdef SPI_SLAVE_MISO_TRI_EN
    logic idle_miso = 1'bz;
`else
    logic idle_miso = 1'b0;
`endif

    // RX scoreboard: every rx_valid cycle pops one expected byte
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            rx_pulses++;
            vectors++;
            if (rx_exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rx_unexpected: got rx_data=%h with nothing expected", bus.rx_data);
            end else begin
                logic [7:0] e;
                e = rx_exp_q.pop_front();
                if (bus.rx_data !== e) begin
                    miscompares++;
                    $display("FAIL rx_data: got %h expected %h", bus.rx_data, e);
                end
            end
        end
    end

    task automatic half_wait();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.tx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL tx_ready_timeout: got tx_ready=%b expected 1", bus.tx_ready);
        end else begin
            bus.tx_data  = d;
            bus.tx_valid = 1'b1;
            miso_exp_q.push_back(d);
            @(negedge clk);
            bus.tx_valid = 1'b0;
        end
    endtask

    task automatic begin_frame(input logic pol, input logic pha);
        CPOL = pol;
        CPHA = pha;
        SCLK = pol;
        half_wait();
        SS_N = 1'b0;
        half_wait();
    endtask

    task automatic end_frame();
        half_wait();
        SS_N = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Master model; a complete byte's MISO is compared with the TX scoreboard
    task automatic xfer_bits(input logic [7:0] tx, input int nbits);
        logic [7:0] rx;
        logic [7:0] e;
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!CPHA) begin
                MOSI = tx[i];
                half_wait();
                rx = {rx[6:0], MISO};
                SCLK = ~CPOL;
                half_wait();
                SCLK = CPOL;
            end else begin
                SCLK = ~CPOL;
                MOSI = tx[i];
                half_wait();
                rx = {rx[6:0], MISO};
                SCLK = CPOL;
                half_wait();
            end
        end
        if (nbits == 8) begin
            vectors++;
            e = (miso_exp_q.size() != 0) ? miso_exp_q.pop_front() : 8'hxx;
            if (rx !== e) begin
                miscompares++;
                $display("FAIL miso_byte: got %h expected %h", rx, e);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({bus.tx_ready, bus.rx_valid, bus.busy, bus.rx_data} !== {1'b1, 1'b0, 1'b0, 8'h00} || MISO !== idle_miso) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b vld=%b busy=%b rx=%h miso=%b expected 1 0 0 00 %b",
                     bus.tx_ready, bus.rx_valid, bus.busy, bus.rx_data, MISO, idle_miso);
        end
    endtask

    task automatic test_mode0();
        int p0;
        p0 = rx_pulses;
        push_tx(8'hA5);
        rx_exp_q.push_back(8'h3C);
        begin_frame(1'b0, 1'b0);
        xfer_bits(8'h3C, 8);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mode0_busy_active: got %b expected 1", bus.busy);
        end
        end_frame();
        vectors++;
        if (bus.busy !== 1'b0 || rx_pulses - p0 != 1) begin
            miscompares++;
            $display("FAIL mode0_end: got busy=%b pulses=%0d expected busy=0 pulses=1", bus.busy, rx_pulses - p0);
        end
    endtask

    task automatic test_mode3();
        push_tx(8'h81);
        rx_exp_q.push_back(8'h7E);
        begin_frame(1'b1, 1'b1);
        xfer_bits(8'h7E, 8);
        end_frame();
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = rx_pulses;
        push_tx(8'h11);
        rx_exp_q.push_back(8'hC3);
        rx_exp_q.push_back(8'h5A);
        begin_frame(1'b0, 1'b0);
        push_tx(8'h22);
        xfer_bits(8'hC3, 8);
        xfer_bits(8'h5A, 8);
        end_frame();
        vectors++;
        if (rx_pulses - p0 != 2) begin
            miscompares++;
            $display("FAIL b2b_pulses: got %0d expected 2", rx_pulses - p0);
        end
    endtask

    task automatic test_partial();
        int p0;
        p0 = rx_pulses;
        begin_frame(1'b0, 1'b0);
        xfer_bits(8'hFF, 4);
        end_frame();
        vectors++;
        if (rx_pulses != p0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL partial_abort: got pulses=%0d busy=%b expected 0 0", rx_pulses - p0, bus.busy);
        end
        miso_exp_q.push_back(8'h00);
        rx_exp_q.push_back(8'h96);
        begin_frame(1'b0, 1'b0);
        xfer_bits(8'h96, 8);
        end_frame();
    endtask

    task automatic test_underrun();
        miso_exp_q.push_back(8'h00);
        rx_exp_q.push_back(8'h69);
        begin_frame(1'b0, 1'b1);
        xfer_bits(8'h69, 8);
        end_frame();
        vectors++;
        if (bus.tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_ready: got %b expected 1", bus.tx_ready);
        end
    endtask

    task automatic test_reset_midframe();
        int p0;
        begin_frame(1'b0, 1'b0);
        xfer_bits(8'hAA, 3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.tx_ready, bus.rx_valid, bus.busy, bus.rx_data} !== {1'b1, 1'b0, 1'b0, 8'h00} || MISO !== idle_miso) begin
            miscompares++;
            $display("FAIL midrst_values: got rdy=%b vld=%b busy=%b rx=%h miso=%b expected 1 0 0 00 %b",
                     bus.tx_ready, bus.rx_valid, bus.busy, bus.rx_data, MISO, idle_miso);
        end
        p0 = rx_pulses;
        for (int k = 0; k < 16; k++) begin
            SCLK = ~SCLK;
            half_wait();
        end
        vectors++;
        if (bus.busy !== 1'b0 || rx_pulses != p0) begin
            miscompares++;
            $display("FAIL midrst_ignore: got busy=%b pulses=%0d expected 0 0", bus.busy, rx_pulses - p0);
        end
        SS_N = 1'b1;
        miso_exp_q.push_back(8'h00);
        rx_exp_q.push_back(8'hF0);
        begin_frame(1'b0, 1'b0);
        xfer_bits(8'hF0, 8);
        end_frame();
    endtask

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_partial();
        test_underrun();
        test_reset_midframe();
        repeat (10) @(negedge clk);
        vectors++;
        if (rx_exp_q.size() != 0 || miso_exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got rx_left=%0d miso_left=%0d expected 0 0",
                     rx_exp_q.size(), miso_exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
